// File: rtl/mask_index_encoder.sv
// Mask-to-index encoder: takes a register mask and emits the binary index of
// each set bit, lowest first, one per output handshake. A new mask can be
// captured on the final transfer of the current one, so consecutive masks
// stream without a bubble.
module mask_index_encoder #(
  parameter int unsigned WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         in_mask,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [$clog2(WIDTH)-1:0] out_index,
  output logic                     out_last,
  output logic                     busy
);

  localparam int unsigned IDXW = $clog2(WIDTH);

  typedef enum logic {StIdle, StEmit} state_e;

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  mask_q, mask_d;
  logic [IDXW-1:0]   index_q, index_d;
  logic              last_q, last_d;
  logic              accept;

  // State register; index/last are registered from the next-state mask
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      mask_q  <= '0;
      index_q <= '0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      index_q <= index_d;
      last_q  <= last_d;
    end
  end

  // Next-state: capture masks, clear the lowest bit on each non-final transfer
  always_comb begin
    state_d = state_q;
    mask_d  = mask_q;
    accept  = in_valid & in_ready;
    unique case (state_q)
      StIdle: begin
        // A zero mask is consumed without producing any beat
        if (accept && (in_mask != '0)) begin
          mask_d  = in_mask;
          state_d = StEmit;
        end
      end
      StEmit: begin
        if (out_ready) begin
          if (!last_q) begin
            // index_q is the lowest set bit, so this clears exactly that bit
            mask_d = mask_q & (mask_q - WIDTH'(1));
          end else if (accept && (in_mask != '0)) begin
            mask_d = in_mask;
          end else begin
            mask_d  = '0;
            state_d = StIdle;
          end
        end
      end
      default: begin
        state_d = StIdle;
        mask_d  = '0;
      end
    endcase
  end

  // Priority encode of the next-state mask; the downward scan lets the lowest bit win
  always_comb begin
    index_d = '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (mask_d[i]) index_d = IDXW'(i);
    end
    last_d = (mask_d != '0) && ((mask_d & (mask_d - WIDTH'(1))) == '0);
  end

  // Outputs; in_ready opens on the final transfer so the next mask follows directly
  always_comb begin
    out_valid = (state_q == StEmit);
    busy      = (state_q == StEmit);
    out_index = index_q;
    out_last  = last_q;
    in_ready  = !rst && ((state_q == StIdle) ||
                         ((state_q == StEmit) && out_ready && last_q));
  end

endmodule

// File: tb/tb_mask_index_encoder.sv
// Directed bench for mask_index_encoder with hand-computed expected beats.
module tb_mask_index_encoder;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_mask;
  logic        out_valid;
  logic        out_ready;
  logic [4:0]  out_index;
  logic        out_last;
  logic        busy;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  always #5 clk = ~clk;

  mask_index_encoder #(.WIDTH(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_mask   (in_mask),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_index (out_index),
    .out_last  (out_last),
    .busy      (busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // Advance one clock; sampling happens 1 time unit after the rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Check the current beat then transfer it
  task automatic beat(input string tag, input int idx, input logic last);
    check({tag, "_valid"}, 32'(out_valid), 32'd1);
    check({tag, "_index"}, 32'(out_index), 32'(idx));
    check({tag, "_last"},  32'(out_last),  32'(last));
    out_ready = 1'b1;
    step();
  endtask

  task automatic idle_chk(input string tag);
    check({tag, "_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_busy"},  32'(busy),      32'd0);
    check({tag, "_ready"}, 32'(in_ready),  32'd1);
  endtask

  // Present one mask for a single cycle (only used while in_ready is 1)
  task automatic send(input logic [31:0] mask);
    in_valid = 1'b1;
    in_mask  = mask;
    #1;
    check("send_ready", 32'(in_ready), 32'd1);
    step();
    in_valid = 1'b0;
    in_mask  = '0;
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_mask   = '0;
    out_ready = 1'b0;

    // 1. Reset
    step();
    step();
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_index", 32'(out_index), 32'd0);
    check("rst_last",  32'(out_last),  32'd0);
    check("rst_busy",  32'(busy),      32'd0);
    check("rst_ready", 32'(in_ready),  32'd0);
    rst = 1'b0;
    #1;
    check("rel_ready", 32'(in_ready), 32'd1);
    step();

    // 2. Mask 0x25 -> 0,2,5
    out_ready = 1'b1;
    send(32'h0000_0025);
    beat("m25_b0", 0, 1'b0);
    beat("m25_b1", 2, 1'b0);
    beat("m25_b2", 5, 1'b1);
    idle_chk("m25_end");

    // 3. Backpressure on 0x8000_0001
    out_ready = 1'b0;
    send(32'h8000_0001);
    for (int c = 0; c < 4; c++) begin
      check("bp_valid", 32'(out_valid), 32'd1);
      check("bp_index", 32'(out_index), 32'd0);
      check("bp_last",  32'(out_last),  32'd0);
      check("bp_ready", 32'(in_ready),  32'd0);
      step();
    end
    beat("bp_b0", 0, 1'b0);
    beat("bp_b1", 31, 1'b1);
    idle_chk("bp_end");

    // 4. Back-to-back: 0x10 then 0x3 captured on the last transfer
    send(32'h0000_0010);
    check("b2b_idx4", 32'(out_index), 32'd4);
    check("b2b_last4", 32'(out_last), 32'd1);
    in_valid = 1'b1;
    in_mask  = 32'h0000_0003;
    #1;
    check("b2b_ready", 32'(in_ready), 32'd1);
    step();
    in_valid = 1'b0;
    in_mask  = '0;
    beat("b2b_b1", 0, 1'b0);
    beat("b2b_b2", 1, 1'b1);
    idle_chk("b2b_end");

    // 5a. Zero mask: consumed, no output
    send(32'h0);
    idle_chk("zero_c1");
    step();
    idle_chk("zero_c2");

    // 5b. Full mask: 32 beats
    send(32'hFFFF_FFFF);
    for (int i = 0; i < 32; i++) beat("full", i, (i == 31));
    idle_chk("full_end");

    // Top bit only: single beat
    send(32'h8000_0000);
    beat("top", 31, 1'b1);
    idle_chk("top_end");

    // 6. Reset mid-stream on 0xF0
    send(32'h0000_00F0);
    beat("mid_b0", 4, 1'b0);
    beat("mid_b1", 5, 1'b0);
    check("mid_pre_idx", 32'(out_index), 32'd6);
    rst = 1'b1;
    step();
    check("mid_rst_valid", 32'(out_valid), 32'd0);
    check("mid_rst_busy",  32'(busy),      32'd0);
    check("mid_rst_ready", 32'(in_ready),  32'd0);
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      step();
      idle_chk("mid_after");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
